// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks.
// Holds the button index constants, the default timing constants for the
// 12 MHz oscillator and the repeat-FSM state type used by button_channel.
// No ports: this is a package.
package pong_pkg;

    // Button channel indices into the btn_* vectors
    localparam int BTN_LEFT  = 0;
    localparam int BTN_START = 1;
    localparam int BTN_RIGHT = 2;

    // Default timing at 12 MHz: ~5.5 ms debounce, ~667 ms first repeat,
    // then a repeat every ~167 ms
    localparam int DEFAULT_DEBOUNCE_CYCLES = 65536;
    localparam int DEFAULT_REPEAT_DELAY    = 8000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 2000000;

    // Auto-repeat state per channel
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } repeatState_t;

    // Counter width for a count of 0..maxCount-1, never narrower than one bit
    function automatic int cntWidth(input int maxCount);
        int w;
        w = $clog2(maxCount);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: polarity fix, two-flop synchroniser, debounce counter,
// press/release pulse generation and the optional auto-repeat FSM.
// Ports:
//   osc_clk    - single clock for all state
//   rst_n      - asynchronous active-low reset, returns to the released state
//   btn_raw_i  - raw asynchronous button pin
//   level_o    - debounced level, 1 = held
//   press_o    - one-cycle pulse when the debounced level rises
//   release_o  - one-cycle pulse when the debounced level falls
//   step_o     - press pulse OR auto-repeat pulse (press only when REPEAT_EN=0)
module button_channel
    import pong_pkg::*;
#(
    parameter bit BTN_ACTIVE_LOW  = 1'b0,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic osc_clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic step_o
);

    localparam int DW = cntWidth(DEBOUNCE_CYCLES);
    localparam int RW = cntWidth((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          pressedRaw;
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          pressEv, releaseEv;
    repeatState_t  state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          repFire;
    logic          press_q, release_q, step_q;

    assign pressedRaw = btn_raw_i ^ BTN_ACTIVE_LOW;

    // Two-flop synchroniser. The raw pin is asynchronous to osc_clk, so
    // nothing downstream looks at it before it has passed both flops.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pressedRaw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new synced value has to hold for DEBOUNCE_CYCLES edges in
    // a row before it becomes the stable level. Any return to the stable
    // value restarts the count. The press/release events fire on the very
    // edge the stable level flips so the pulses line up with the level.
    always_comb begin
        dcnt_d    = dcnt_q;
        stable_d  = stable_q;
        pressEv   = 1'b0;
        releaseEv = 1'b0;
        if (sync2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            stable_d  = sync2_q;
            dcnt_d    = '0;
            pressEv   = sync2_q;
            releaseEv = ~sync2_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // Auto-repeat next-state logic. Entering DELAY on the press event itself
    // puts the first repeat exactly REPEAT_DELAY cycles after the press
    // pulse. A release always wins and suppresses a repeat in that cycle.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        repFire = 1'b0;
        if (releaseEv) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pressEv && REPEAT_EN) begin
                        state_d = DELAY;
                        rcnt_d  = '0;
                    end
                end
                DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        repFire = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        repFire = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    // State and output registers. Every output comes straight from a flop so
    // the game logic never sees a combinational path from the pins.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= 1'b0;
            dcnt_q    <= '0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            press_q   <= pressEv;
            release_q <= releaseEv;
            step_q    <= pressEv | repFire;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign step_o    = step_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the pong game: turns the raw bouncy pins into
// clean synchronous levels, press/release pulses and auto-repeat steps.
// Ports:
//   osc_clk     - oscillator clock, single clock for all state
//   rst_n       - asynchronous active-low reset
//   btn_raw     - raw button pins (bit 0 left, 1 start, 2 right)
//   btn_level   - debounced level per button, 1 = held
//   btn_press   - one-cycle pulse on debounced press
//   btn_release - one-cycle pulse on debounced release
//   btn_step    - press pulse plus auto-repeat pulses where REPEAT_MASK is set
module button_conditioner
    import pong_pkg::*;
#(
    parameter int                 NUM_BTN         = 3,
    parameter bit                 BTN_ACTIVE_LOW  = 1'b0,
    parameter int                 DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int                 REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int                 REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b101
) (
    input  logic               osc_clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_step
);

    // Channels are fully independent; each one gets its own copy of the
    // conditioning pipeline with repeat enabled from its mask bit.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_chan (
            .osc_clk  (osc_clk),
            .rst_n    (rst_n),
            .btn_raw_i(btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .step_o   (btn_step[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner. Two instances run side by side,
// one with active-high pins and one with active-low pins, against a model
// that works from the sampled input history and press timestamps.
module tb_button_conditioner;

    localparam int             DEB  = 4;
    localparam int             DLY  = 10;
    localparam int             PER  = 3;
    localparam logic [2:0]     MASK = 3'b101;

    logic       oscClk;
    logic       rstN;
    logic [2:0] rawH, rawL;
    logic [2:0] lvlH, pressH, relH, stepH;
    logic [2:0] lvlL, pressL, relL, stepL;

    int checks;
    int errors;
    int edgeNo;

    // Model state, index [dut][channel]; dut 0 = active high, 1 = active low
    logic [31:0] nHist     [2][3];
    logic        stableM   [2][3];
    int          pressEdge [2][3];
    logic [2:0]  expLvl [2];
    logic [2:0]  expPress [2];
    logic [2:0]  expRel [2];
    logic [2:0]  expStep [2];

    button_conditioner #(
        .NUM_BTN(3), .BTN_ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .REPEAT_MASK(MASK)
    ) dutH (
        .osc_clk(oscClk), .rst_n(rstN), .btn_raw(rawH),
        .btn_level(lvlH), .btn_press(pressH), .btn_release(relH), .btn_step(stepH)
    );

    button_conditioner #(
        .NUM_BTN(3), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .REPEAT_MASK(MASK)
    ) dutL (
        .osc_clk(oscClk), .rst_n(rstN), .btn_raw(rawL),
        .btn_level(lvlL), .btn_press(pressL), .btn_release(relL), .btn_step(stepL)
    );

    initial oscClk = 1'b0;
    always #5 oscClk = ~oscClk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] h, input logic [2:0] l);
        rawH = h;
        rawL = l;
    endtask

    // Advance k active edges and stop on the following falling edge
    task automatic afterEdge(input int k);
        repeat (k) @(posedge oscClk);
        @(negedge oscClk);
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                nHist[d][c]     = 32'd0;
                stableM[d][c]   = 1'b0;
                pressEdge[d][c] = 0;
            end
            expLvl[d]   = 3'b000;
            expPress[d] = 3'b000;
            expRel[d]   = 3'b000;
            expStep[d]  = 3'b000;
        end
    endtask

    // A value seen by the design two edges after it was sampled becomes the
    // level once it has been seen DEB edges in a row. Repeats follow from
    // the press timestamp: DLY after, then every PER, never on the release.
    task automatic modelStep(input int d, input logic [2:0] raw);
        logic [2:0]  n;
        logic [31:0] win;
        logic [31:0] full;
        int          k;
        n    = raw ^ ((d == 1) ? 3'b111 : 3'b000);
        full = (32'd1 << DEB) - 32'd1;
        expPress[d] = 3'b000;
        expRel[d]   = 3'b000;
        expStep[d]  = 3'b000;
        for (int c = 0; c < 3; c++) begin
            nHist[d][c] = {nHist[d][c][30:0], n[c]};
            win = (nHist[d][c] >> 2) & full;
            if (!stableM[d][c] && win == full) begin
                stableM[d][c]   = 1'b1;
                expPress[d][c]  = 1'b1;
                expStep[d][c]   = 1'b1;
                pressEdge[d][c] = edgeNo;
            end else if (stableM[d][c] && win == 32'd0) begin
                stableM[d][c] = 1'b0;
                expRel[d][c]  = 1'b1;
            end else if (stableM[d][c] && MASK[c]) begin
                k = edgeNo - pressEdge[d][c];
                if (k >= DLY && ((k - DLY) % PER) == 0) expStep[d][c] = 1'b1;
            end
            expLvl[d][c] = stableM[d][c];
        end
    endtask

    // Compare process: inputs are captured on the active edge, the model is
    // advanced and all outputs are compared on the following falling edge.
    initial begin : compareProc
        logic [2:0] sH, sL;
        logic       rstAtEdge;
        modelReset();
        forever begin
            @(posedge oscClk);
            sH        = rawH;
            sL        = rawL;
            rstAtEdge = rstN;
            edgeNo++;
            @(negedge oscClk);
            if (!rstN || !rstAtEdge) begin
                modelReset();
            end else begin
                modelStep(0, sH);
                modelStep(1, sL);
            end
            checkOutput("H.level",   int'(lvlH),   int'(expLvl[0]));
            checkOutput("H.press",   int'(pressH), int'(expPress[0]));
            checkOutput("H.release", int'(relH),   int'(expRel[0]));
            checkOutput("H.step",    int'(stepH),  int'(expStep[0]));
            checkOutput("L.level",   int'(lvlL),   int'(expLvl[1]));
            checkOutput("L.press",   int'(pressL), int'(expPress[1]));
            checkOutput("L.release", int'(relL),   int'(expRel[1]));
            checkOutput("L.step",    int'(stepL),  int'(expStep[1]));
        end
    end

    initial begin : stimProc
        int cnt;
        int cnt2;
        int flipRange;
        checks = 0;
        errors = 0;
        edgeNo = 0;
        rstN   = 1'b0;
        applyStimulus(3'b000, 3'b111);
        repeat (3) @(posedge oscClk);
        #2 rstN = 1'b1;
        @(negedge oscClk);

        // Active-low pins idle high: nothing may happen
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            afterEdge(1);
            if ((lvlL | pressL | relL | stepL) != 3'b000) cnt++;
        end
        checkOutput("lowIdleQuiet", cnt, 0);
        applyStimulus(3'b000, 3'b110);
        afterEdge(5);
        checkOutput("lowPressE5", int'(pressL), 0);
        afterEdge(1);
        checkOutput("lowPressE6", int'(pressL), 1);
        checkOutput("lowLevelE6", int'(lvlL), 1);
        applyStimulus(3'b000, 3'b111);
        afterEdge(12);

        // Clean press on left, held 40 edges, then released
        applyStimulus(3'b001, 3'b111);
        afterEdge(5);
        checkOutput("leftLevelE5", int'(lvlH), 0);
        afterEdge(1);
        checkOutput("leftLevelE6", int'(lvlH), 1);
        checkOutput("leftPressE6", int'(pressH), 1);
        checkOutput("leftStepE6", int'(stepH), 1);
        afterEdge(1);
        checkOutput("leftPressE7", int'(pressH), 0);
        afterEdge(8);
        checkOutput("leftStepE15", int'(stepH), 0);
        afterEdge(1);
        checkOutput("leftStepE16", int'(stepH), 1);
        afterEdge(3);
        checkOutput("leftStepE19", int'(stepH), 1);
        afterEdge(1);
        checkOutput("leftStepE20", int'(stepH), 0);
        afterEdge(20);
        applyStimulus(3'b000, 3'b111);
        afterEdge(3);
        checkOutput("leftStepDuringRelDebounce", int'(stepH), 1);
        afterEdge(3);
        checkOutput("leftReleaseE6", int'(relH), 1);
        checkOutput("leftNoStepOnRelease", int'(stepH), 0);
        checkOutput("leftLevelOff", int'(lvlH), 0);
        afterEdge(12);

        // Bounce on right: 1,0,1,1,0 then steady 1
        applyStimulus(3'b100, 3'b111); afterEdge(1);
        applyStimulus(3'b000, 3'b111); afterEdge(1);
        applyStimulus(3'b100, 3'b111); afterEdge(1);
        applyStimulus(3'b100, 3'b111); afterEdge(1);
        applyStimulus(3'b000, 3'b111); afterEdge(1);
        applyStimulus(3'b100, 3'b111);
        afterEdge(5);
        checkOutput("bounceLevelE5", int'(lvlH), 0);
        afterEdge(1);
        checkOutput("bounceLevelE6", int'(lvlH), 4);
        checkOutput("bouncePressE6", int'(pressH), 4);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            afterEdge(1);
            if (pressH[2]) cnt++;
        end
        checkOutput("bounceSinglePress", cnt, 0);
        applyStimulus(3'b000, 3'b111);
        afterEdge(12);

        // Start held 50 edges: one press, no repeats
        applyStimulus(3'b010, 3'b111);
        cnt  = 0;
        cnt2 = 0;
        for (int i = 0; i < 50; i++) begin
            afterEdge(1);
            if (pressH[1]) cnt++;
            if (stepH[1]) cnt2++;
        end
        checkOutput("startPressCount", cnt, 1);
        checkOutput("startStepCount", cnt2, 1);
        applyStimulus(3'b000, 3'b111);
        afterEdge(12);

        // Left and right together, then release left only
        applyStimulus(3'b101, 3'b111);
        afterEdge(6);
        checkOutput("dualPressE6", int'(pressH), 5);
        checkOutput("dualStepE6", int'(stepH), 5);
        afterEdge(10);
        checkOutput("dualStepE16", int'(stepH), 5);
        afterEdge(3);
        checkOutput("dualStepE19", int'(stepH), 5);
        applyStimulus(3'b100, 3'b111);
        afterEdge(6);
        checkOutput("leftOnlyRelease", int'(relH), 1);
        checkOutput("rightOnlyStepE25", int'(stepH), 4);
        afterEdge(3);
        checkOutput("rightOnlyStepE28", int'(stepH), 4);
        applyStimulus(3'b000, 3'b111);
        afterEdge(12);

        // Reset in the REPEAT state with the button still held
        applyStimulus(3'b001, 3'b111);
        afterEdge(20);
        @(posedge oscClk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstAsyncLevel", int'(lvlH), 0);
        checkOutput("rstAsyncPress", int'(pressH), 0);
        checkOutput("rstAsyncRelease", int'(relH), 0);
        repeat (3) @(posedge oscClk);
        #2 rstN = 1'b1;
        afterEdge(5);
        checkOutput("postRstPressE5", int'(pressH), 0);
        afterEdge(1);
        checkOutput("postRstPressE6", int'(pressH), 1);
        checkOutput("postRstLevelE6", int'(lvlH), 1);
        applyStimulus(3'b000, 3'b111);
        afterEdge(12);

        // Random activity, with slow and fast toggling phases and rare resets
        flipRange = 3;
        for (int i = 0; i < 1600; i++) begin
            if ((i % 100) == 0) flipRange = ($urandom_range(0, 1) == 0) ? 3 : 31;
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, flipRange) == 0) rawH[b] = ~rawH[b];
                if ($urandom_range(0, flipRange) == 0) rawL[b] = ~rawL[b];
            end
            if ($urandom_range(0, 399) == 0) begin
                @(posedge oscClk);
                #2 rstN = 1'b0;
                @(posedge oscClk);
                #2 rstN = 1'b1;
                @(negedge oscClk);
            end else begin
                afterEdge(1);
            end
        end

        afterEdge(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
